// File: rtl/ddr_rd_burst_ctrl.sv
// ddr_rd_burst_ctrl: issues a burst of MIG read commands with address stepping and forwards the returned beats
module ddr_rd_burst_ctrl #(
  parameter int APP_ADDR_WD   = 29,
  parameter int BURST_ADDR_WD = 64,
  parameter int DDR_DATA_WD   = 512,
  parameter int LEN_WD        = 10,
  parameter int ADDR_STEP     = 8,
  parameter int DGBCNT_WD     = 16
) (
  input  logic                     ddr_clk,
  input  logic                     ddr_rst,
  input  logic                     cfg_rst,
  input  logic                     rd_burst_req,
  input  logic [LEN_WD-1:0]        rd_burst_len,
  input  logic [BURST_ADDR_WD-1:0] rd_burst_addr,
  output logic                     rd_burst_data_valid,
  output logic [DDR_DATA_WD-1:0]   rd_burst_data,
  output logic                     rd_burst_finish,
  output logic                     app_en,
  output logic [2:0]               app_cmd,
  output logic [APP_ADDR_WD-1:0]   app_addr,
  input  logic                     app_rdy,
  input  logic [DDR_DATA_WD-1:0]   app_rd_data,
  input  logic                     app_rd_data_valid,
  input  logic                     dbg_cnt_clr,
  output logic [DGBCNT_WD-1:0]     dbg_burst_cnt,
  output logic [DGBCNT_WD-1:0]     dbg_stray_cnt
);
  typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;
  state_t                   state_q, state_d;
  logic [APP_ADDR_WD-1:0]   addr_q, addr_d;
  logic [LEN_WD-1:0]        len_q, len_d, cmd_cnt_q, cmd_cnt_d, dat_cnt_q, dat_cnt_d, dat_nxt;
  logic                     vld_q, vld_d;
  logic [DDR_DATA_WD-1:0]   data_q, data_d;
  logic [DGBCNT_WD-1:0]     burst_cnt_q, burst_cnt_d, stray_cnt_q, stray_cnt_d;
  logic                     unused_addr_hi;

  assign unused_addr_hi      = ^rd_burst_addr[BURST_ADDR_WD-1:APP_ADDR_WD];
  assign app_cmd             = 3'b001;
  assign app_en              = state_q == CMD;
  assign app_addr            = app_en ? addr_q + APP_ADDR_WD'(cmd_cnt_q) * APP_ADDR_WD'(ADDR_STEP) : '0;
  assign rd_burst_finish     = state_q == DONE;
  assign rd_burst_data_valid = vld_q;
  assign rd_burst_data       = data_q;
  assign dbg_burst_cnt       = burst_cnt_q;
  assign dbg_stray_cnt       = stray_cnt_q;
  assign dat_nxt             = dat_cnt_q + LEN_WD'(app_rd_data_valid);

  // next-state: burst sequencing, beat counting, debug counters and soft reset
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cmd_cnt_d   = cmd_cnt_q;
    dat_cnt_d   = dat_cnt_q;
    vld_d       = app_rd_data_valid;
    data_d      = app_rd_data;
    burst_cnt_d = state_q == DONE && ~&burst_cnt_q ? burst_cnt_q + 1'b1 : burst_cnt_q;
    stray_cnt_d = state_q == IDLE && app_rd_data_valid && ~&stray_cnt_q ? stray_cnt_q + 1'b1 : stray_cnt_q;
    case (state_q)
      IDLE: if (rd_burst_req) begin
        state_d   = rd_burst_len == '0 ? DONE : CMD;
        addr_d    = rd_burst_addr[APP_ADDR_WD-1:0];
        len_d     = rd_burst_len;
        cmd_cnt_d = '0;
        dat_cnt_d = '0;
      end
      CMD: begin
        dat_cnt_d = dat_nxt;
        cmd_cnt_d = app_rdy ? cmd_cnt_q + 1'b1 : cmd_cnt_q;
        state_d   = app_rdy && cmd_cnt_q == len_q - 1'b1 ? WAIT : CMD;
      end
      WAIT: begin
        dat_cnt_d = dat_nxt;
        state_d   = dat_nxt == len_q ? DONE : WAIT;
      end
      default: state_d = IDLE;
    endcase
    if (dbg_cnt_clr) begin
      burst_cnt_d = '0;
      stray_cnt_d = '0;
    end
    if (cfg_rst) begin
      state_d     = IDLE;
      addr_d      = '0;
      len_d       = '0;
      cmd_cnt_d   = '0;
      dat_cnt_d   = '0;
      vld_d       = 1'b0;
      data_d      = '0;
      burst_cnt_d = '0;
      stray_cnt_d = '0;
    end
  end

  // state and datapath registers
  always_ff @(posedge ddr_clk or posedge ddr_rst) begin
    if (ddr_rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      cmd_cnt_q   <= '0;
      dat_cnt_q   <= '0;
      vld_q       <= 1'b0;
      data_q      <= '0;
      burst_cnt_q <= '0;
      stray_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cmd_cnt_q   <= cmd_cnt_d;
      dat_cnt_q   <= dat_cnt_d;
      vld_q       <= vld_d;
      data_q      <= data_d;
      burst_cnt_q <= burst_cnt_d;
      stray_cnt_q <= stray_cnt_d;
    end
  end
endmodule

// File: tb/tb_ddr_rd_burst_ctrl.sv
// tb_ddr_rd_burst_ctrl: scoreboard bench with a MIG model for ddr_rd_burst_ctrl
module tb_ddr_rd_burst_ctrl;
  localparam int AW = 29, DW = 512, LW = 10, DCW = 16;
  logic clk = 1'b0;
  logic rst, cfg_rst, req, clr;
  logic [LW-1:0] len;
  logic [63:0] addr;
  logic vld, fin, app_en, app_rdy, app_rd_data_valid;
  logic [DW-1:0] dat, app_rd_data;
  logic [2:0] app_cmd;
  logic [AW-1:0] app_addr;
  logic [DCW-1:0] bcnt, scnt;

  ddr_rd_burst_ctrl dut (
    .ddr_clk(clk), .ddr_rst(rst), .cfg_rst(cfg_rst),
    .rd_burst_req(req), .rd_burst_len(len), .rd_burst_addr(addr),
    .rd_burst_data_valid(vld), .rd_burst_data(dat), .rd_burst_finish(fin),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .dbg_cnt_clr(clr), .dbg_burst_cnt(bcnt), .dbg_stray_cnt(scnt)
  );

  always #5 clk = ~clk;

  typedef struct { int t; logic [DW-1:0] d; bit stray; } ret_t;
  typedef struct { int t; logic [DW-1:0] d; bit fin; } beat_t;
  ret_t pend[$];
  beat_t exp_beats[$];
  logic [AW-1:0] exp_addr[$];
  int burst_lens[$];
  int cyc = 0;
  int n_tests = 0, n_fail = 0;
  int beat_idx = 0, exp_zero = 0, exp_bursts = 0, exp_stray = 0;
  int fin_cnt = 0, fin_cyc = 0, acc_cnt = 0, last_t = 0, req_cyc = 0;
  int rdy_mode = 0, lat_lo = 5, lat_hi = 5, pi = 0;
  logic [6:0] pat = 7'b1011001;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // MIG model: accept commands and schedule in-order read returns
  always @(negedge clk) begin
    int t;
    if (!rst && app_en && app_rdy) begin
      t = cyc + $urandom_range(lat_hi, lat_lo);
      if (t <= last_t) t = last_t + 1;
      last_t = t;
      pend.push_back('{t, rnd_data(), 1'b0});
      acc_cnt++;
    end
  end

  // MIG model: drive app_rdy and returned data; record expected forwarded beats
  initial begin
    ret_t r;
    bit fb;
    app_rdy = 1'b0;
    app_rd_data_valid = 1'b0;
    app_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      app_rdy = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (app_en ? (pi < 7 ? pat[pi] : 1'b1) : 1'b0) : 1'($urandom_range(1, 0));
      if (rdy_mode == 1 && app_en && pi < 7) pi++;
      app_rd_data_valid = 1'b0;
      app_rd_data = rnd_data();
      if (pend.size() > 0 && pend[0].t <= cyc) begin
        r = pend.pop_front();
        app_rd_data_valid = 1'b1;
        app_rd_data = r.d;
        fb = 1'b0;
        if (r.stray) exp_stray++;
        else begin
          beat_idx++;
          fb = burst_lens.size() > 0 && beat_idx == burst_lens[0];
          if (fb) begin
            void'(burst_lens.pop_front());
            beat_idx = 0;
          end
        end
        exp_beats.push_back('{cyc + 1, r.d, fb});
      end
    end
  end

  // monitor: commands, address stability and forwarded beats
  bit prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  beat_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        chk("app_en_held", app_en, 1);
        chk("app_addr_held", app_addr, prev_addr);
      end
      prev_stall = app_en && !app_rdy;
      prev_addr = app_addr;
      if (app_en && app_rdy) begin
        chk("app_cmd", app_cmd, 3'b001);
        if (exp_addr.size() == 0) chk("unexpected_cmd", app_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("app_addr", app_addr, exp_addr.pop_front());
      end
      if (vld) begin
        if (exp_beats.size() == 0) chk("unexpected_beat", vld, 0);
        else begin
          mon_e = exp_beats.pop_front();
          chk("beat_cycle", cyc, mon_e.t);
          chk("beat_data_ok", dat === mon_e.d, 1);
          chk("finish_on_last_beat", fin, mon_e.fin);
        end
      end else if (fin) begin
        chk("zero_len_finish_expected", exp_zero > 0, 1);
        if (exp_zero > 0) exp_zero--;
      end
      if (fin) begin
        fin_cnt++;
        fin_cyc = cyc;
      end
    end
  end

  task automatic push_burst(input logic [63:0] a, input int n);
    if (n == 0) exp_zero++;
    else begin
      burst_lens.push_back(n);
      for (int i = 0; i < n; i++) exp_addr.push_back(AW'(a + 64'(i) * 64'd8));
    end
  endtask

  task automatic do_burst(input logic [63:0] a, input int n, input bit keep);
    int f0, k;
    f0 = fin_cnt;
    req = 1'b1;
    addr = a;
    len = LW'(n);
    req_cyc = cyc;
    push_burst(a, n);
    if (n != 0) begin
      @(negedge clk);
      chk("app_en_low_at_req", app_en, 0);
      @(negedge clk);
      chk("app_en_after_req", app_en, 1);
    end
    k = 0;
    while (fin_cnt == f0 && k < 4000) begin
      @(posedge clk);
      k++;
    end
    chk("finish_seen", fin_cnt != f0, 1);
    if (n == 0) chk("zero_len_finish_latency", fin_cyc - req_cyc, 1);
    #1;
    exp_bursts++;
    chk("dbg_burst_cnt", bcnt, exp_bursts);
    if (!keep) req = 1'b0;
  endtask

  function automatic logic [63:0] rnd_addr();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int a0, f0, k;
    logic [63:0] ra;
    rst = 1'b1;
    cfg_rst = 1'b0;
    req = 1'b0;
    clr = 1'b0;
    len = '0;
    addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_app_en", app_en, 0);
    chk("rst_app_addr", app_addr, 0);
    chk("rst_valid", vld, 0);
    chk("rst_data_zero", dat == '0, 1);
    chk("rst_finish", fin, 0);
    chk("rst_burst_cnt", bcnt, 0);
    chk("rst_stray_cnt", scnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_burst(64'h100, 1, 1'b0);
    rdy_mode = 1;
    pi = 0;
    lat_lo = 2;
    lat_hi = 4;
    do_burst(64'h1000, 4, 1'b0);
    rdy_mode = 0;
    lat_lo = 2;
    lat_hi = 2;
    do_burst(rnd_addr(), 8, 1'b1);
    do_burst(rnd_addr(), 2, 1'b0);
    do_burst(rnd_addr(), 0, 1'b0);
    do_burst({32'hDEAD_BEEF, 3'b0, 29'h1FFF_FFF8}, 2, 1'b0);
    // abandon a 16-beat burst after three accepted commands
    lat_lo = 12;
    lat_hi = 12;
    a0 = acc_cnt;
    f0 = fin_cnt;
    ra = rnd_addr();
    req = 1'b1;
    addr = ra;
    len = LW'(16);
    push_burst(ra, 16);
    k = 0;
    while (acc_cnt - a0 < 3 && k < 100) begin
      @(posedge clk);
      k++;
    end
    chk("three_cmds_accepted", acc_cnt - a0 >= 3, 1);
    #1;
    cfg_rst = 1'b1;
    req = 1'b0;
    @(posedge clk);
    #1;
    cfg_rst = 1'b0;
    foreach (pend[i]) pend[i].stray = 1'b1;
    exp_addr.delete();
    if (burst_lens.size() > 0) void'(burst_lens.pop_front());
    beat_idx = 0;
    exp_bursts = 0;
    @(negedge clk);
    chk("cfgrst_app_en", app_en, 0);
    chk("cfgrst_app_addr", app_addr, 0);
    chk("cfgrst_valid", vld, 0);
    chk("cfgrst_finish", fin, 0);
    chk("cfgrst_burst_cnt", bcnt, 0);
    chk("cfgrst_stray_cnt", scnt, 0);
    k = 0;
    while (pend.size() > 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("stray_cnt", scnt, exp_stray);
    chk("no_finish_after_abort", fin_cnt, f0);
    lat_lo = 3;
    lat_hi = 6;
    do_burst(rnd_addr(), 5, 1'b0);
    // randomized bursts
    rdy_mode = 2;
    lat_lo = 1;
    lat_hi = 8;
    for (int i = 0; i < 25; i++)
      do_burst(rnd_addr(), $urandom_range(3, 0) == 0 ? 0 : $urandom_range(24, 1), 1'($urandom_range(1, 0)));
    do_burst(rnd_addr(), 40, 1'b0);
    // debug counter clear
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    exp_bursts = 0;
    exp_stray = 0;
    chk("dbg_clr_burst", bcnt, 0);
    chk("dbg_clr_stray", scnt, 0);
    for (int i = 0; i < 3; i++) do_burst(rnd_addr(), $urandom_range(6, 1), 1'b0);
    chk("dbg_burst_cnt_three", bcnt, 3);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("dbg_burst_cnt_cleared", bcnt, 0);
    k = 0;
    while ((pend.size() > 0 || exp_beats.size() > 0) && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain_beats", exp_beats.size(), 0);
    chk("drain_addrs", exp_addr.size(), 0);
    chk("drain_bursts", burst_lens.size(), 0);
    chk("drain_zero", exp_zero, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
